fsm3_seq_tracker: RTL and testbench



---
 rtl/fsm3_seq_tracker_if.sv | 26 ++
 rtl/fsm3_seq_tracker.sv | 112 +++++++++++
 tb/tb_fsm3_seq_tracker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm3_seq_tracker_if.sv
// Event stream interface for fsm3_seq_tracker.
// Carries the logged completion index from the tracker to its consumer
// using a valid/ready handshake.
//   evt_valid : producer has a head entry available
//   evt_ready : consumer accepts the head entry this cycle
//   evt_idx   : bit index of the head entry
// master = tracker side, slave = consumer side.
interface fsm3_seq_tracker_if #(
    parameter int IDX_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/fsm3_seq_tracker.sv
// Sequential back-end of the 4-state "101" detector.
// Holds the state register feeding the external next-state logic, tracks the
// stream bit position, counts completions (saturating) and logs the index of
// each completing bit into a first-word-fall-through event FIFO.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   bit_valid    : current input bit is valid; state/index advance only then
//   next_state   : next state from the combinational block (A=0..D=3)
//   state        : registered current state, fed to the combinational block
//   evt          : event stream (evt_valid / evt_ready / evt_idx), master side
//   fifo_level   : number of stored events
//   match_count  : total detections, saturating
//   overflow     : sticky flag, an event was dropped on a full FIFO
module fsm3_seq_tracker #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_valid,
    input  logic [1:0]                 next_state,
    output logic [1:0]                 state,
    fsm3_seq_tracker_if.master         evt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } st_e;

    st_e              state_q;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic [IDX_W-1:0] mem [DEPTH];

    logic detect;
    logic full;
    logic pop;
    logic push;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the transition into D completes a pattern; sitting in D while
    // bit_valid is low must not count again.
    assign detect = bit_valid && (next_state == 2'd3);
    assign full   = (level == LVL_W'(DEPTH));
    assign pop    = (level != '0) && evt.evt_ready;
    // On a full FIFO a simultaneous pop frees the slot for this push.
    assign push   = detect && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_A;
            bit_idx <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
        end else begin
            if (bit_valid) begin
                state_q <= st_e'(next_state);
                bit_idx <= bit_idx + 1'b1;
            end
            if (detect) begin
                cnt_q <= sat_inc(cnt_q);
            end
            if (detect && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the level counter gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bit_idx;
        end
    end

    assign state       = state_q;
    assign fifo_level  = level;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;
    assign evt.evt_valid = (level != '0);
    assign evt.evt_idx   = (level != '0) ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_fsm3_seq_tracker.sv
module tb_fsm3_seq_tracker;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       in_bit;
    logic [1:0] state8, next_state8;
    logic [1:0] state2, next_state2;
    logic [2:0] fifo_level8, fifo_level2;
    logic [7:0] match_count8, match_count2;
    logic       overflow8, overflow2;

    fsm3_seq_tracker_if #(.IDX_W(8)) if8 ();
    fsm3_seq_tracker_if #(.IDX_W(2)) if2 ();

    always #5 clk = ~clk;

    // "101" detector next-state logic: A=none, B=saw 1, C=saw 10, D=saw 101
    function automatic logic [1:0] ns_f(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd1 : 2'd2;
        endcase
    endfunction

    assign next_state8 = ns_f(state8, in_bit);
    assign next_state2 = ns_f(state2, in_bit);

    fsm3_seq_tracker #(.IDX_W(8), .CNT_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .next_state(next_state8),
        .state(state8), .evt(if8), .fifo_level(fifo_level8),
        .match_count(match_count8), .overflow(overflow8)
    );

    fsm3_seq_tracker #(.IDX_W(2), .CNT_W(8), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .next_state(next_state2),
        .state(state2), .evt(if2), .fifo_level(fifo_level2),
        .match_count(match_count2), .overflow(overflow2)
    );

    int tests = 0;
    int fails = 0;

    // reference model
    logic [1:0] m_state;
    logic [7:0] m_idx;
    logic [7:0] m_cnt;
    logic       m_ovf;
    logic [7:0] exp_q [$];

    task automatic model_reset();
        m_state = 2'd0;
        m_idx   = 8'd0;
        m_cnt   = 8'd0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Called at a negedge: checks outputs, applies inputs for the next
    // posedge, updates the model/scoreboard, then advances to next negedge.
    task automatic step(input logic v, input logic b, input logic r);
        logic det, pop;
        bit_valid = v;
        in_bit    = b;
        if8.evt_ready = r;
        tests++;
        if (state8 !== m_state) begin
            fails++; $display("FAIL state: got %0d want %0d", state8, m_state);
        end
        tests++;
        if (fifo_level8 !== 3'(exp_q.size())) begin
            fails++; $display("FAIL fifo_level: got %0d want %0d", fifo_level8, exp_q.size());
        end
        tests++;
        if (if8.evt_valid !== (exp_q.size() != 0)) begin
            fails++; $display("FAIL evt_valid: got %0d want %0d", if8.evt_valid, exp_q.size() != 0);
        end
        tests++;
        if (match_count8 !== m_cnt) begin
            fails++; $display("FAIL match_count: got %0d want %0d", match_count8, m_cnt);
        end
        tests++;
        if (overflow8 !== m_ovf) begin
            fails++; $display("FAIL overflow: got %0d want %0d", overflow8, m_ovf);
        end
        if (exp_q.size() == 0) begin
            tests++;
            if (if8.evt_idx !== 8'd0) begin
                fails++; $display("FAIL evt_idx_empty: got %0d want 0", if8.evt_idx);
            end
        end
        pop = (exp_q.size() != 0) && r;
        if (pop) begin
            tests++;
            if (if8.evt_idx !== exp_q[0]) begin
                fails++; $display("FAIL evt_idx_pop: got %0d want %0d", if8.evt_idx, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        det = v && (ns_f(m_state, b) == 2'd3);
        if (det) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (exp_q.size() < DEPTH || pop) exp_q.push_back(m_idx);
            else m_ovf = 1'b1;
        end
        if (v) begin
            m_state = ns_f(m_state, b);
            m_idx   = m_idx + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic v);
        reset     = 1'b1;
        bit_valid = v;
        in_bit    = 1'b1;
        if8.evt_ready = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        bit_valid = 1'b0;
        model_reset();
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic r);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], r);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
        tests++;
        if (exp_q.size() != 0 || if8.evt_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty: got valid %0d want 0", if8.evt_valid);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tests++;
        if (if8.evt_valid !== 1'b0 || if8.evt_idx !== 8'd0 || fifo_level8 !== 3'd0) begin
            fails++; $display("FAIL reset_fifo: got valid %0d idx %0d lvl %0d want 0 0 0",
                              if8.evt_valid, if8.evt_idx, fifo_level8);
        end
        tests++;
        if (state8 !== 2'd0 || match_count8 !== 8'd0 || overflow8 !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got st %0d cnt %0d ovf %0d want 0 0 0",
                              state8, match_count8, overflow8);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic [1:0] want [3];
        do_reset(1'b0);
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i != 1), 1'b0);
            tests++;
            if (state8 !== want[i]) begin
                fails++; $display("FAIL basic_state%0d: got %0d want %0d", i, state8, want[i]);
            end
        end
        tests++;
        if (if8.evt_valid !== 1'b1 || if8.evt_idx !== 8'd2 || match_count8 !== 8'd1 || fifo_level8 !== 3'd1) begin
            fails++; $display("FAIL basic_event: got v%0d idx%0d cnt%0d lvl%0d want v1 idx2 cnt1 lvl1",
                              if8.evt_valid, if8.evt_idx, match_count8, fifo_level8);
        end
        drain(2);
    endtask

    task automatic test_overlap();
        do_reset(1'b0);
        send_bits(16'b10101, 5, 1'b1);
        drain(3);
        tests++;
        if (match_count8 !== 8'd2 || overflow8 !== 1'b0) begin
            fails++; $display("FAIL overlap: got cnt %0d ovf %0d want 2 0", match_count8, overflow8);
        end
    endtask

    task automatic test_gap();
        do_reset(1'b0);
        send_bits(16'b10, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            tests++;
            if (state8 !== 2'd2) begin
                fails++; $display("FAIL gap_hold: got %0d want 2", state8);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if (if8.evt_idx !== 8'd2 || fifo_level8 !== 3'd1) begin
            fails++; $display("FAIL gap_event: got idx %0d lvl %0d want 2 1", if8.evt_idx, fifo_level8);
        end
        drain(2);
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        send_bits(16'b10101010101, 11, 1'b0);
        tests++;
        if (fifo_level8 !== 3'd4 || overflow8 !== 1'b1 || match_count8 !== 8'd5) begin
            fails++; $display("FAIL overflow_state: got lvl %0d ovf %0d cnt %0d want 4 1 5",
                              fifo_level8, overflow8, match_count8);
        end
        drain(5);
        tests++;
        if (overflow8 !== 1'b1) begin
            fails++; $display("FAIL overflow_sticky: got %0d want 1", overflow8);
        end
    endtask

    task automatic test_full_simul();
        do_reset(1'b0);
        send_bits(16'b101010101, 9, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        tests++;
        if (fifo_level8 !== 3'd4 || overflow8 !== 1'b0) begin
            fails++; $display("FAIL full_simul: got lvl %0d ovf %0d want 4 0", fifo_level8, overflow8);
        end
        drain(5);
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        send_bits(16'b10101010, 8, 1'b0);
        tests++;
        if (fifo_level8 !== 3'd3 || state8 !== 2'd2) begin
            fails++; $display("FAIL mid_setup: got lvl %0d st %0d want 3 2", fifo_level8, state8);
        end
        do_reset(1'b1);
        tests++;
        if (if8.evt_valid !== 1'b0 || state8 !== 2'd0 || match_count8 !== 8'd0 || overflow8 !== 1'b0) begin
            fails++; $display("FAIL mid_reset: got v%0d st%0d cnt%0d ovf%0d want 0 0 0 0",
                              if8.evt_valid, state8, match_count8, overflow8);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idx_wrap();
        do_reset(1'b0);
        send_bits(16'b000101, 6, 1'b0);
        tests++;
        if (if2.evt_valid !== 1'b1 || if2.evt_idx !== 2'd1) begin
            fails++; $display("FAIL idx_wrap: got v%0d idx %0d want v1 idx 1", if2.evt_valid, if2.evt_idx);
        end
        drain(2);
    endtask

    initial begin
        reset = 1'b1;
        bit_valid = 1'b0;
        in_bit = 1'b0;
        if8.evt_ready = 1'b0;
        if2.evt_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_overlap();
        test_gap();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_idx_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
